// File: rtl/control_bus_rtc.sv
// Bus sequencer for the multiplexed RTC address/data bus: one full write or read
// transaction per request, with setup/pulse/hold timing per phase.
module control_bus_rtc #(
    parameter logic [7:0] T_SET   = 8'd2,
    parameter logic [7:0] T_PULSO = 8'd4,
    parameter logic [7:0] T_HOLD  = 8'd2
) (
    input  logic clk,
    input  logic reset,
    input  logic iniciar_escritura,
    input  logic iniciar_lectura,
    output logic selector,
    output logic selector2,
    output logic bus_oe,
    output logic cs_n,
    output logic a_d,
    output logic wr_n,
    output logic rd_n,
    output logic captura,
    output logic ocupado,
    output logic listo
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DIR_SET   = 3'd1,
        DIR_PULSO = 3'd2,
        DIR_HOLD  = 3'd3,
        DAT_SET   = 3'd4,
        DAT_PULSO = 3'd5,
        DAT_HOLD  = 3'd6,
        FIN       = 3'd7
    } state_t;

    // Last counter value of each timed state; a zero length behaves as one cycle.
    localparam logic [7:0] SET_LAST   = (T_SET   == 8'd0) ? 8'd0 : T_SET   - 8'd1;
    localparam logic [7:0] PULSO_LAST = (T_PULSO == 8'd0) ? 8'd0 : T_PULSO - 8'd1;
    localparam logic [7:0] HOLD_LAST  = (T_HOLD  == 8'd0) ? 8'd0 : T_HOLD  - 8'd1;

    state_t     state_q, state_d;
    logic       es_lectura_q, es_lectura_d;
    logic [7:0] cnt_q, cnt_d;

    logic selector_q, selector_d;
    logic selector2_q, selector2_d;
    logic bus_oe_q, bus_oe_d;
    logic cs_n_q, cs_n_d;
    logic a_d_q, a_d_d;
    logic wr_n_q, wr_n_d;
    logic rd_n_q, rd_n_d;
    logic captura_q, captura_d;
    logic ocupado_q, ocupado_d;
    logic listo_q, listo_d;

    always_comb begin
        state_d      = state_q;
        es_lectura_d = es_lectura_q;
        cnt_d        = cnt_q + 8'd1;
        unique case (state_q)
            IDLE: begin
                cnt_d = 8'd0;
                if (iniciar_escritura) begin
                    es_lectura_d = 1'b0;
                    state_d      = DIR_SET;
                end else if (iniciar_lectura) begin
                    es_lectura_d = 1'b1;
                    state_d      = DIR_SET;
                end
            end
            DIR_SET: if (cnt_q == SET_LAST) begin
                state_d = DIR_PULSO;
                cnt_d   = 8'd0;
            end
            DIR_PULSO: if (cnt_q == PULSO_LAST) begin
                state_d = DIR_HOLD;
                cnt_d   = 8'd0;
            end
            DIR_HOLD: if (cnt_q == HOLD_LAST) begin
                state_d = DAT_SET;
                cnt_d   = 8'd0;
            end
            DAT_SET: if (cnt_q == SET_LAST) begin
                state_d = DAT_PULSO;
                cnt_d   = 8'd0;
            end
            DAT_PULSO: if (cnt_q == PULSO_LAST) begin
                state_d = DAT_HOLD;
                cnt_d   = 8'd0;
            end
            DAT_HOLD: if (cnt_q == HOLD_LAST) begin
                state_d = FIN;
                cnt_d   = 8'd0;
            end
            FIN: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered copy lines up with state_q.
    always_comb begin
        selector_d  = 1'b0;
        selector2_d = 1'b0;
        bus_oe_d    = 1'b0;
        cs_n_d      = 1'b1;
        a_d_d       = 1'b1;
        wr_n_d      = 1'b1;
        rd_n_d      = 1'b1;
        captura_d   = 1'b0;
        ocupado_d   = (state_d != IDLE);
        listo_d     = (state_d == FIN);
        unique case (state_d)
            DIR_SET, DIR_HOLD: begin
                selector_d = 1'b1;
                bus_oe_d   = 1'b1;
                cs_n_d     = 1'b0;
                a_d_d      = 1'b0;
            end
            DIR_PULSO: begin
                selector_d = 1'b1;
                bus_oe_d   = 1'b1;
                cs_n_d     = 1'b0;
                a_d_d      = 1'b0;
                wr_n_d     = 1'b0;
            end
            DAT_SET, DAT_HOLD: begin
                cs_n_d      = 1'b0;
                selector2_d = !es_lectura_d;
                bus_oe_d    = !es_lectura_d;
            end
            DAT_PULSO: begin
                cs_n_d      = 1'b0;
                selector2_d = !es_lectura_d;
                bus_oe_d    = !es_lectura_d;
                if (es_lectura_d) begin
                    rd_n_d    = 1'b0;
                    captura_d = (cnt_d == PULSO_LAST);
                end else begin
                    wr_n_d = 1'b0;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            es_lectura_q <= 1'b0;
            cnt_q        <= 8'd0;
            selector_q   <= 1'b0;
            selector2_q  <= 1'b0;
            bus_oe_q     <= 1'b0;
            cs_n_q       <= 1'b1;
            a_d_q        <= 1'b1;
            wr_n_q       <= 1'b1;
            rd_n_q       <= 1'b1;
            captura_q    <= 1'b0;
            ocupado_q    <= 1'b0;
            listo_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            es_lectura_q <= es_lectura_d;
            cnt_q        <= cnt_d;
            selector_q   <= selector_d;
            selector2_q  <= selector2_d;
            bus_oe_q     <= bus_oe_d;
            cs_n_q       <= cs_n_d;
            a_d_q        <= a_d_d;
            wr_n_q       <= wr_n_d;
            rd_n_q       <= rd_n_d;
            captura_q    <= captura_d;
            ocupado_q    <= ocupado_d;
            listo_q      <= listo_d;
        end
    end

    assign selector  = selector_q;
    assign selector2 = selector2_q;
    assign bus_oe    = bus_oe_q;
    assign cs_n      = cs_n_q;
    assign a_d       = a_d_q;
    assign wr_n      = wr_n_q;
    assign rd_n      = rd_n_q;
    assign captura   = captura_q;
    assign ocupado   = ocupado_q;
    assign listo     = listo_q;

endmodule

// File: doc/control_bus_rtc.md
Name: control_bus_rtc

Overview:
Sequencer for the multiplexed 8-bit address/data bus to the RTC. It drives the two priority-select inputs of the 3-input bus mux: selector=1 routes the address byte, selector2=1 routes the write-data byte, and both low route the idle byte. It generates the bus strobes for one complete write or read transaction. It also tells the microcontroller FSM when a transaction is finished and when read data is valid on the bus.

Parameters:
T_SET, 2, cycles a phase's bus value is held before its strobe falls (setup)
T_PULSO, 4, cycles the WR/RD strobe is held low
T_HOLD, 2, cycles the bus value is held after the strobe rises
- All three are 8-bit values. A value of 0 behaves as 1.

Ports:
clk  input  1  system clock; all state changes on its rising edge
reset  input  1  asynchronous, active-low; low forces IDLE immediately
iniciar_escritura  input  1  write request; sampled only in IDLE
iniciar_lectura  input  1  read request; sampled only in IDLE
selector  output  1  to bus mux; 1 = address byte on bus
selector2  output  1  to bus mux; 1 = write-data byte on bus (when selector=0)
bus_oe  output  1  tri-state enable for the AD bus drivers (1 = block drives bus)
cs_n  output  1  RTC chip select, active-low
a_d  output  1  0 = address phase, 1 = data phase or idle
wr_n  output  1  write strobe, active-low
rd_n  output  1  read strobe, active-low
captura  output  1  one-cycle pulse; the read byte on the bus is valid to latch
ocupado  output  1  1 in every state except IDLE
listo  output  1  one-cycle pulse when a transaction completes

Behaviour:
- Reset values: selector=0, selector2=0, bus_oe=0, cs_n=1, a_d=1, wr_n=1, rd_n=1, captura=0, ocupado=0, listo=0, state=IDLE, counter=0, mode flag=0.
- Outputs are Moore outputs decoded from the state register and the latched mode flag es_lectura. captura also depends on the counter.
- States: IDLE, DIR_SET, DIR_PULSO, DIR_HOLD, DAT_SET, DAT_PULSO, DAT_HOLD, FIN.
- IDLE:
  - If iniciar_escritura=1, latch es_lectura=0 and go to DIR_SET.
  - Otherwise, if iniciar_lectura=1, latch es_lectura=1 and go to DIR_SET.
  - If both are 1, the write wins.
- A per-state 8-bit counter is cleared on every state entry. Each timed state lasts exactly its parameter's number of cycles, then advances in the order listed above. FIN lasts 1 cycle, then returns to IDLE.
- Total transaction length: 2*(T_SET+T_PULSO+T_HOLD)+1 cycles. With the defaults this is 17 cycles.
- DIR_SET / DIR_HOLD: selector=1, bus_oe=1, cs_n=0, a_d=0, wr_n=1.
- DIR_PULSO: as DIR_SET, but wr_n=0. The address is latched by the RTC on the wr_n rising edge, regardless of mode.
- DAT_SET / DAT_HOLD: cs_n=0, a_d=1, selector=0.
  - Write: selector2=1, bus_oe=1.
  - Read: selector2=0, bus_oe=0 (bus released).
- DAT_PULSO:
  - Write: wr_n=0.
  - Read: rd_n=0, and captura=1 only on the last cycle of DAT_PULSO.
- FIN: all strobes high, cs_n=1, bus_oe=0, selectors 0, listo=1.
- cs_n stays low continuously from DIR_SET through DAT_HOLD. wr_n and rd_n are never low simultaneously.
- Requests arriving while ocupado=1 are ignored, not queued.
- A request held high through FIN is accepted in the IDLE cycle that follows, so back-to-back transactions are separated by exactly one IDLE cycle.
- Reset asserted mid-transaction: all outputs take their reset values asynchronously. No partial listo or captura is emitted. After release, the block is in IDLE.

Test Plan:
- Reset then idle: hold reset low 3 cycles, release, no requests -> all outputs at reset values for 20 cycles.
- Default write: 1-cycle pulse on iniciar_escritura.
  - selector=1 for cycles 1-8; wr_n low cycles 3-6.
  - selector2=1 for cycles 9-16; wr_n low cycles 11-14.
  - listo=1 at cycle 17; ocupado high cycles 1-17.
- Default read: 1-cycle pulse on iniciar_lectura.
  - Address phase identical to the write case.
  - bus_oe=0 in cycles 9-16; rd_n low cycles 11-14; captura=1 only at cycle 14; listo at 17.
- Simultaneous requests in IDLE, then iniciar_lectura pulsed at cycle 5 -> write transaction only; no read starts; listo once at 17.
- Reset dropped during DAT_PULSO of a write -> wr_n=1, cs_n=1, selector2=0 immediately; after release, ocupado=0 and no listo pulse.
- T_SET=0, T_PULSO=1, T_HOLD=1 with a read request -> every phase lasts 1 cycle; total 7 cycles; captura coincides with the single rd_n-low cycle.
